// File: rtl/wb_stage.sv
// Writeback stage: captures the memory-stage bundle, commits bytes into the 32x32 register file,
// and exposes read ports, the forwarding tap, the debug trace and a retire counter.
// Optional same-cycle write-to-read bypass is built when REGFILE_BYPASS_EN is defined.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_in,
  output logic        wb_allowin_out,
  input  logic [31:0] mem_wbdata_in,
  input  logic [3:0]  mem_reg_we_in,
  input  logic [4:0]  mem_wnum_in,
  input  logic [31:0] mem_PC_in,
  input  logic [4:0]  rf_raddr1_in,
  input  logic [4:0]  rf_raddr2_in,
  output logic [31:0] rf_rdata1_out,
  output logic [31:0] rf_rdata2_out,
  output logic [4:0]  wb_wnum_out,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] retired_cnt_out
);

  logic        valid_q;
  logic [31:0] data_q;
  logic [3:0]  we_q;
  logic [4:0]  wnum_q;
  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic [31:0] rf_q [32];

  logic        accept;
  logic [3:0]  eff_we;

  // The stage never back-pressures the memory stage.
  assign wb_allowin_out = 1'b1;
  assign accept         = mem_valid_in & wb_allowin_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      we_q    <= '0;
      wnum_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q <= mem_wbdata_in;
        we_q   <= mem_reg_we_in;
        wnum_q <= mem_wnum_in;
        pc_q   <= mem_PC_in;
      end
    end
  end

  // Writes to r0 are squashed here, so rf_q[0] is never touched after reset.
  assign eff_we = we_q & {4{valid_q && (wnum_q != 5'd0)}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (eff_we[b]) begin
          rf_q[wnum_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (valid_q) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  function automatic logic [31:0] rf_read(input logic [4:0] addr);
    logic [31:0] word;
    word = '0;
    if (addr != 5'd0) begin
      word = rf_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (valid_q && (addr == wnum_q)) begin
        for (int b = 0; b < 4; b++) begin
          if (eff_we[b]) begin
            word[8*b +: 8] = data_q[8*b +: 8];
          end
        end
      end
`endif
    end
    return word;
  endfunction

  always_comb begin
    rf_rdata1_out = rf_read(rf_raddr1_in);
    rf_rdata2_out = rf_read(rf_raddr2_in);
  end

  assign wb_wnum_out       = wnum_q & {5{valid_q}};
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = eff_we;
  assign debug_wb_rf_wnum  = wnum_q;
  assign debug_wb_rf_wdata = data_q;
  assign retired_cnt_out   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected trace entries, a negedge monitor
// pops and compares them whenever an instruction occupies WB.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid_in;
  logic        wb_allowin_out;
  logic [31:0] mem_wbdata_in;
  logic [3:0]  mem_reg_we_in;
  logic [4:0]  mem_wnum_in;
  logic [31:0] mem_PC_in;
  logic [4:0]  rf_raddr1_in;
  logic [4:0]  rf_raddr2_in;
  logic [31:0] rf_rdata1_out;
  logic [31:0] rf_rdata2_out;
  logic [4:0]  wb_wnum_out;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt_out;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [4:0]  fwd;
  } trace_t;

  trace_t exp_q[$];
  trace_t mon_e;
  logic   in_wb;
  int     n_cmp;
  int     n_err;

  wb_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid_in      (mem_valid_in),
    .wb_allowin_out    (wb_allowin_out),
    .mem_wbdata_in     (mem_wbdata_in),
    .mem_reg_we_in     (mem_reg_we_in),
    .mem_wnum_in       (mem_wnum_in),
    .mem_PC_in         (mem_PC_in),
    .rf_raddr1_in      (rf_raddr1_in),
    .rf_raddr2_in      (rf_raddr2_in),
    .rf_rdata1_out     (rf_rdata1_out),
    .rf_rdata2_out     (rf_rdata2_out),
    .wb_wnum_out       (wb_wnum_out),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retired_cnt_out   (retired_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Bench-side occupancy: an instruction offered with valid at an edge sits in WB next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_wb <= 1'b0;
    else        in_wb <= mem_valid_in;
  end

  always @(negedge clk) begin
    if (in_wb) begin
      if (exp_q.size() == 0) begin
        check("trace_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("trace_pc", debug_wb_pc, mon_e.pc);
        check("trace_wen", {28'd0, debug_wb_rf_wen}, {28'd0, mon_e.wen});
        check("trace_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, mon_e.wnum});
        check("trace_wdata", debug_wb_rf_wdata, mon_e.wdata);
        check("trace_fwd", {27'd0, wb_wnum_out}, {27'd0, mon_e.fwd});
      end
    end else begin
      check("idle_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
      check("idle_fwd", {27'd0, wb_wnum_out}, 32'd0);
    end
  end

  task automatic issue(input logic [4:0] wnum, input logic [3:0] we, input logic [31:0] data,
                       input logic [31:0] pc, input logic [3:0] exp_wen, input logic [4:0] exp_fwd);
    trace_t t;
    @(posedge clk);
    #1;
    mem_valid_in  = 1'b1;
    mem_wnum_in   = wnum;
    mem_reg_we_in = we;
    mem_wbdata_in = data;
    mem_PC_in     = pc;
    t.pc = pc; t.wen = exp_wen; t.wnum = wnum; t.wdata = data; t.fwd = exp_fwd;
    exp_q.push_back(t);
  endtask

  // Stale payload stays on the bus to show it is ignored without valid.
  task automatic bubble();
    @(posedge clk);
    #1;
    mem_valid_in  = 1'b0;
    mem_wnum_in   = 5'd9;
    mem_reg_we_in = 4'b1111;
    mem_wbdata_in = 32'hDEADBEEF;
    mem_PC_in     = 32'hBAD0BAD0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    rf_raddr1_in = addr;
    rf_raddr2_in = addr;
    #1;
    check({name, "_p1"}, rf_rdata1_out, exp);
    check({name, "_p2"}, rf_rdata2_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mem_valid_in = 1'b0;
    mem_wbdata_in = '0;
    mem_reg_we_in = '0;
    mem_wnum_in = '0;
    mem_PC_in = '0;
    rf_raddr1_in = 5'd5;
    rf_raddr2_in = 5'd7;
    #2;
    check("rst_allowin", {31'd0, wb_allowin_out}, 32'd1);
    check("rst_pc", debug_wb_pc, 32'd0);
    check("rst_wdata", debug_wb_rf_wdata, 32'd0);
    check("rst_cnt", retired_cnt_out, 32'd0);
    check("rst_rd1", rf_rdata1_out, 32'd0);
    #10;
    rst_n = 1'b1;

    // Full write
    issue(5'd5, 4'b1111, 32'h12345678, 32'hBFC00010, 4'b1111, 5'd5);
    bubble();
    bubble();
    read_chk("full_r5", 5'd5, 32'h12345678);
    check("full_cnt", retired_cnt_out, 32'd1);

    // Byte merge, including the same-cycle read while the merge is in WB
    issue(5'd5, 4'b0011, 32'hAAAABBCC, 32'hBFC00014, 4'b0011, 5'd5);
    bubble();
`ifdef REGFILE_BYPASS_EN
    read_chk("merge_same", 5'd5, 32'h1234BBCC);
`else
    read_chk("merge_same", 5'd5, 32'h12345678);
`endif
    bubble();
    read_chk("merge_after", 5'd5, 32'h1234BBCC);
    check("merge_cnt", retired_cnt_out, 32'd2);

    // r0 protection
    issue(5'd0, 4'b1111, 32'hFFFFFFFF, 32'hBFC00018, 4'b0000, 5'd0);
    bubble();
    read_chk("r0_same", 5'd0, 32'd0);
    bubble();
    read_chk("r0_after", 5'd0, 32'd0);
    check("r0_cnt", retired_cnt_out, 32'd3);

    // Bubbles with stale payload aimed at r9
    bubble();
    bubble();
    bubble();
    read_chk("bub_r9", 5'd9, 32'd0);
    read_chk("bub_r5", 5'd5, 32'h1234BBCC);
    check("bub_cnt", retired_cnt_out, 32'd3);

    // Back-to-back writes to r7
    issue(5'd7, 4'b1111, 32'h1, 32'hBFC00020, 4'b1111, 5'd7);
    issue(5'd7, 4'b1111, 32'h2, 32'hBFC00024, 4'b1111, 5'd7);
    issue(5'd7, 4'b1111, 32'h3, 32'hBFC00028, 4'b1111, 5'd7);
    bubble();
    bubble();
    read_chk("b2b_r7", 5'd7, 32'h3);
    check("b2b_cnt", retired_cnt_out, 32'd6);

    // Fill to 16 retired with the 17th instruction (r12) sitting in WB
    for (int k = 0; k < 11; k++) begin
      logic [4:0] wn;
      wn = (k < 10) ? 5'(k + 1) : 5'd12;
      issue(wn, 4'b1111, 32'h100 + 32'(k), 32'hBFC00100 + 32'(4 * k), 4'b1111, wn);
    end
    bubble();
    check("pre_rst_cnt", retired_cnt_out, 32'h10);
    check("pre_rst_fwd", {27'd0, wb_wnum_out}, 32'd12);
    read_chk("pre_rst_r1", 5'd1, 32'h100);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnt", retired_cnt_out, 32'd0);
    check("mid_rst_pc", debug_wb_pc, 32'd0);
    check("mid_rst_wnum", {27'd0, debug_wb_rf_wnum}, 32'd0);
    check("mid_rst_wdata", debug_wb_rf_wdata, 32'd0);
    check("mid_rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    check("mid_rst_fwd", {27'd0, wb_wnum_out}, 32'd0);
    check("mid_rst_allowin", {31'd0, wb_allowin_out}, 32'd1);
    exp_q.delete();
    for (int r = 1; r < 32; r++) begin
      rf_raddr1_in = 5'(r);
      #0;
      #1;
      check("mid_rst_rf", rf_rdata1_out, 32'd0);
    end
    @(posedge clk);
    #1;
    read_chk("rst_edge_r12", 5'd12, 32'd0);
    check("rst_edge_cnt", retired_cnt_out, 32'd0);
    rst_n = 1'b1;

    // First capture after release
    issue(5'd3, 4'b1111, 32'h55, 32'hBFC00200, 4'b1111, 5'd3);
    bubble();
    bubble();
    read_chk("post_rst_r3", 5'd3, 32'h55);
    check("post_rst_cnt", retired_cnt_out, 32'd1);
    bubble();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
